hash_multi: RTL and testbench
=============================

# hash_multi

Parametrised, multi-mode successor to the fixed-width key hash unit. It accepts a key of up to KEY_BYTES bytes with a per-request byte length and a selectable algorithm (FNV-1a-32 or CRC-32/IEEE). It hashes the key iteratively at one byte per cycle and returns a 32-bit digest with a start/ready handshake. It sits in front of the match-table index logic and feeds `DATA_BUS`-wide hash values to the lookup stage.

## Interface
- KEY_BYTES, 8: maximum key length in bytes; key_i is 8*KEY_BYTES bits wide.
- LEN_W, $clog2(KEY_BYTES+1): width of len_i; derived, do not override.
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start_i  in  1  request strobe; accepted only when busy_o is low.
- mode_i  in  1  0 = FNV-1a-32, 1 = CRC-32 (reflected, poly 0xEDB88320).
- len_i  in  LEN_W  key length in bytes, 0..KEY_BYTES.
- key_i  in  8*KEY_BYTES  key; byte k = key_i[8k+7:8k]; bytes processed k = 0 upward.
- busy_o  out  1  high while a request is in flight.
- hash_ready_o  out  1  one-cycle pulse; hash_val_o is valid and new.
- hash_val_o  out  32  digest; holds until the next result.

## Operation
- States: IDLE, RUN, FIN.
- IDLE with start_i=1:
  - Register key_i, mode_i and min(len_i, KEY_BYTES).
  - Byte counter = 0.
  - Accumulator = 0x811C9DC5 (FNV) or 0xFFFFFFFF (CRC).
  - Go to RUN.
- RUN: each cycle, if counter < len, process byte[counter], then counter+1. When counter == len, go to FIN without processing.
- FNV step: acc = (acc ^ byte) * 0x01000193, truncated to 32 bits.
- CRC step: acc ^= byte, then 8 iterations of acc = (acc>>1) ^ (acc[0] ? 0xEDB88320 : 0).
  - Purely combinational within one cycle.
- FIN:
  - hash_val_o <= acc (FNV) or acc ^ 0xFFFFFFFF (CRC).
  - hash_ready_o <= 1.
  - Go to IDLE.
- busy_o = (state != IDLE).
- start_i while busy_o=1 is ignored; no queueing, no error flag.
- Inputs are sampled only on the accept edge. Later changes to key_i, len_i or mode_i do not affect the request in flight.
- len_i > KEY_BYTES is clamped to KEY_BYTES.
- len_i = 0 yields the empty-key digest: 0x811C9DC5 (FNV) or 0x00000000 (CRC).

## Timing
- Reset values: busy_o=0, hash_ready_o=0, hash_val_o=0, state=IDLE, accumulator=0, counter=0.
- Edge sequence for a request accepted at edge T:
  - Edge T: accept.
  - Edges T+1..T+len: process bytes.
  - Edge T+len+1: RUN→FIN transition.
  - Edge T+len+2: digest registered; hash_ready_o high for the following cycle only.
- Latency from accept edge to hash_ready_o rising: len+2 cycles. busy_o is high from edge T to edge T+len+2, i.e. len+2 cycles.
- Back-to-back: start_i high in the hash_ready_o cycle is accepted, since the state is IDLE. Sustained throughput is one result per len+3 cycles.
- hash_ready_o never stays high for two consecutive cycles.
- rst asserted mid-request:
  - Immediately returns to reset values and discards the request.
  - No hash_ready_o follows.
  - The first start_i after deassertion is accepted normally.

## Test plan
- FNV, key bytes 0..5 = "foobar" (key_i[47:0] = 0x7261_626F_6F66), len 6, mode 0 -> hash_ready_o 8 cycles after accept, hash_val_o = 0xBF9CF968.
- FNV, len 1, byte 0 = 0x61 ("a") -> 0xE40C292C. CRC, same key -> 0xE8B7BE43.
- CRC, instance with KEY_BYTES=9, "123456789" (byte 0 = 0x31), len 9 -> 0xCBF43926 after 11 cycles.
- len 0: mode 0 -> 0x811C9DC5, mode 1 -> 0x00000000. Both with latency 2. len 12 on KEY_BYTES=8 -> identical result to len 8.
- start_i held high continuously, key 0x61, len 1, mode 0:
  - Requests are accepted every 4 cycles.
  - Each hash_ready_o is a single-cycle pulse with 0xE40C292C.
  - Changing key_i or mode_i while busy has no effect.
- Assert rst 2 cycles into a len-8 request:
  - All outputs return to 0 asynchronously.
  - No hash_ready_o pulse follows.
  - A new "a" FNV request then yields 0xE40C292C.

Source files
------------

// File: rtl/hash_multi.sv
// ---------------------------------------------------------------------------
// hash_multi
//   Iterative key hash unit. A request carries a key of up to KEY_BYTES
//   bytes, a byte length and an algorithm select. The key is folded into a
//   32-bit accumulator one byte per cycle, lowest byte first, and the
//   finished digest is presented with a single-cycle ready pulse.
//
//   Algorithms:
//     mode 0 : FNV-1a-32   (offset basis 0x811C9DC5, prime 0x01000193)
//     mode 1 : CRC-32/IEEE (reflected, poly 0xEDB88320, init/xorout all-ones)
//
// Ports:
//   clk           in   clock, rising edge
//   rst           in   asynchronous active-high reset
//   start_i       in   request strobe, taken only while busy_o is low
//   mode_i        in   algorithm select (0 = FNV-1a, 1 = CRC-32)
//   len_i         in   key length in bytes; values above KEY_BYTES clamp
//   key_i         in   key, byte k at key_i[8k+7:8k]
//   busy_o        out  request in flight
//   hash_ready_o  out  one-cycle pulse, hash_val_o is new
//   hash_val_o    out  digest, held until the next result
// ---------------------------------------------------------------------------
module hash_multi #(
    parameter int KEY_BYTES = 8,
    parameter int LEN_W     = $clog2(KEY_BYTES + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_i,
    input  logic                   mode_i,
    input  logic [LEN_W-1:0]       len_i,
    input  logic [8*KEY_BYTES-1:0] key_i,
    output logic                   busy_o,
    output logic                   hash_ready_o,
    output logic [31:0]            hash_val_o
);

    localparam logic [31:0]      FNV_BASIS = 32'h811C_9DC5;
    localparam logic [31:0]      FNV_PRIME = 32'h0100_0193;
    localparam logic [31:0]      CRC_POLY  = 32'hEDB8_8320;
    localparam logic [31:0]      CRC_INIT  = 32'hFFFF_FFFF;
    localparam logic [LEN_W-1:0] MAX_LEN   = LEN_W'(KEY_BYTES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t                 state_reg, state_next;
    logic [8*KEY_BYTES-1:0] key_reg, key_next;
    logic                   mode_reg, mode_next;
    logic [LEN_W-1:0]       len_reg, len_next;
    logic [LEN_W-1:0]       cnt_reg, cnt_next;
    logic [31:0]            acc_reg, acc_next;
    logic [31:0]            val_reg, val_next;
    logic                   ready_reg, ready_next;

    logic [7:0]             key_byte [KEY_BYTES];
    logic [7:0]             cur_byte;

    // One FNV-1a round: xor the byte in, then multiply (mod 2^32).
    function automatic logic [31:0] fnv_step(input logic [31:0] acc, input logic [7:0] b);
        logic [31:0] x;
        x = acc ^ {24'h0, b};
        return x * FNV_PRIME;
    endfunction

    // One reflected CRC-32 byte round, fully unrolled into combinational logic.
    function automatic logic [31:0] crc_step(input logic [31:0] acc, input logic [7:0] b);
        logic [31:0] c;
        c = acc ^ {24'h0, b};
        for (int i = 0; i < 8; i++) begin
            c = (c >> 1) ^ (c[0] ? CRC_POLY : 32'h0);
        end
        return c;
    endfunction

    // Split the captured key into byte lanes.
    generate
        for (genvar gi = 0; gi < KEY_BYTES; gi++) begin : g_lane
            assign key_byte[gi] = key_reg[8*gi +: 8];
        end
    endgenerate

    // Byte selected by the counter. The counter reaches len_reg (possibly
    // KEY_BYTES) on the final RUN cycle, where no byte is consumed, so the
    // out-of-range case simply yields zero.
    always_comb begin
        cur_byte = 8'h00;
        for (int i = 0; i < KEY_BYTES; i++) begin
            if (cnt_reg == LEN_W'(i)) begin
                cur_byte = key_byte[i];
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        key_next   = key_reg;
        mode_next  = mode_reg;
        len_next   = len_reg;
        cnt_next   = cnt_reg;
        acc_next   = acc_reg;
        val_next   = val_reg;
        ready_next = 1'b0;

        case (state_reg)
            IDLE: begin
                if (start_i) begin
                    key_next   = key_i;
                    mode_next  = mode_i;
                    len_next   = (len_i > MAX_LEN) ? MAX_LEN : len_i;
                    cnt_next   = '0;
                    acc_next   = mode_i ? CRC_INIT : FNV_BASIS;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (cnt_reg == len_reg) begin
                    state_next = FIN;
                end else begin
                    acc_next = mode_reg ? crc_step(acc_reg, cur_byte)
                                        : fnv_step(acc_reg, cur_byte);
                    cnt_next = cnt_reg + LEN_W'(1);
                end
            end
            FIN: begin
                // CRC output is the complemented register; FNV is used as-is.
                val_next   = mode_reg ? ~acc_reg : acc_reg;
                ready_next = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            key_reg   <= '0;
            mode_reg  <= 1'b0;
            len_reg   <= '0;
            cnt_reg   <= '0;
            acc_reg   <= '0;
            val_reg   <= '0;
            ready_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            key_reg   <= key_next;
            mode_reg  <= mode_next;
            len_reg   <= len_next;
            cnt_reg   <= cnt_next;
            acc_reg   <= acc_next;
            val_reg   <= val_next;
            ready_reg <= ready_next;
        end
    end

    assign busy_o       = (state_reg != IDLE);
    assign hash_ready_o = ready_reg;
    assign hash_val_o   = val_reg;

endmodule

// File: tb/tb_hash_multi.sv
// ---------------------------------------------------------------------------
// tb_hash_multi
//   Directed bench for hash_multi: an 8-byte instance for most checks and a
//   9-byte instance for the CRC "123456789" check value.
// ---------------------------------------------------------------------------
module tb_hash_multi;

    logic        clk;
    logic        rst;

    logic        start8, mode8;
    logic [3:0]  len8;
    logic [63:0] key8;
    logic        busy8, rdy8;
    logic [31:0] val8;

    logic        start9, mode9;
    logic [3:0]  len9;
    logic [71:0] key9;
    logic        busy9, rdy9;
    logic [31:0] val9;

    int tests_run = 0;
    int failed    = 0;

    hash_multi #(.KEY_BYTES(8)) u_dut8 (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start8),
        .mode_i       (mode8),
        .len_i        (len8),
        .key_i        (key8),
        .busy_o       (busy8),
        .hash_ready_o (rdy8),
        .hash_val_o   (val8)
    );

    hash_multi #(.KEY_BYTES(9)) u_dut9 (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start9),
        .mode_i       (mode9),
        .len_i        (len9),
        .key_i        (key9),
        .busy_o       (busy9),
        .hash_ready_o (rdy9),
        .hash_val_o   (val9)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference FNV-1a over the first n bytes of k.
    function automatic logic [31:0] fnv_ref(input logic [63:0] k, input int n);
        logic [31:0] h;
        h = 32'h811C9DC5;
        for (int i = 0; i < n; i++) begin
            h = (h ^ {24'h0, k[8*i +: 8]}) * 32'h01000193;
        end
        return h;
    endfunction

    // Reference bit-serial reflected CRC-32 over the first n bytes of k.
    function automatic logic [31:0] crc_ref(input logic [63:0] k, input int n);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < 8*n; i++) begin
            if (c[0] ^ k[i]) c = (c >> 1) ^ 32'hEDB88320;
            else             c = c >> 1;
        end
        return ~c;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for rdy8; n = edges from the accept edge.
    task automatic wait_rdy8(output int n);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!rdy8 && n < 50);
    endtask

    // One request on the 8-byte instance; inputs are scrambled right after
    // the accept edge to show they are not re-sampled.
    task automatic req8(input string tag, input logic m, input logic [3:0] l,
                        input logic [63:0] k, input int exp_lat, input logic [31:0] exp);
        int n;
        start8 = 1'b1; mode8 = m; len8 = l; key8 = k;
        @(posedge clk); #1;
        start8 = 1'b0; mode8 = ~m; len8 = 4'd3; key8 = ~k;
        check({tag, "_busy"}, {31'h0, busy8}, 32'h1);
        wait_rdy8(n);
        check({tag, "_lat"}, 32'(n), 32'(exp_lat));
        check({tag, "_val"}, val8, exp);
        $display("[TB] %s mode=%0d len=%0d latency=%0d hash=%h", tag, m, l, n, val8);
        @(posedge clk); #1;
        check({tag, "_pulse"}, {31'h0, rdy8}, 32'h0);
    endtask

    initial begin
        int n;
        int pulses;
        logic [63:0] k8;

        rst = 1'b1;
        start8 = 1'b0; mode8 = 1'b0; len8 = '0; key8 = '0;
        start9 = 1'b0; mode9 = 1'b0; len9 = '0; key9 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", {31'h0, busy8}, 32'h0);
        check("rst_ready", {31'h0, rdy8}, 32'h0);
        check("rst_val", val8, 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        req8("fnv_foobar", 1'b0, 4'd6, 64'h0000_7261_626F_6F66, 8, 32'hBF9CF968);
        req8("fnv_a",      1'b0, 4'd1, 64'h61, 3, 32'hE40C292C);
        req8("crc_a",      1'b1, 4'd1, 64'h61, 3, 32'hE8B7BE43);
        req8("fnv_len0",   1'b0, 4'd0, 64'h1234, 2, 32'h811C9DC5);
        req8("crc_len0",   1'b1, 4'd0, 64'h1234, 2, 32'h00000000);

        k8 = 64'h8877_6655_4433_2211;
        req8("fnv_len8",   1'b0, 4'd8,  k8, 10, fnv_ref(k8, 8));
        req8("fnv_len12",  1'b0, 4'd12, k8, 10, fnv_ref(k8, 8));
        req8("crc_len12",  1'b1, 4'd12, k8, 10, crc_ref(k8, 8));

        // CRC check value on the 9-byte instance.
        start9 = 1'b1; mode9 = 1'b1; len9 = 4'd9; key9 = 72'h39_3837_3635_3433_3231;
        @(posedge clk); #1;
        start9 = 1'b0; key9 = '0;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!rdy9 && n < 50);
        check("crc9_lat", 32'(n), 32'd11);
        check("crc9_val", val9, 32'hCBF43926);
        $display("[TB] crc9 latency=%0d hash=%h", n, val9);
        @(posedge clk); #1;

        // start_i held high: one accept every 4 cycles, inputs scrambled in flight.
        start8 = 1'b1; mode8 = 1'b0; len8 = 4'd1; key8 = 64'h61;
        for (int r = 0; r < 3; r++) begin
            @(posedge clk); #1;
            check("b2b_busy", {31'h0, busy8}, 32'h1);
            check("b2b_single", {31'h0, rdy8}, 32'h0);
            mode8 = 1'b1; key8 = 64'hFFFF_FFFF_FFFF_FFFF;
            wait_rdy8(n);
            check("b2b_lat", 32'(n), 32'd3);
            check("b2b_val", val8, 32'hE40C292C);
            $display("[TB] b2b round=%0d latency=%0d hash=%h", r, n, val8);
            mode8 = 1'b0; key8 = 64'h61;
        end
        start8 = 1'b0;
        @(posedge clk); #1;
        check("b2b_end_pulse", {31'h0, rdy8}, 32'h0);
        check("b2b_end_idle", {31'h0, busy8}, 32'h0);

        // Reset two cycles into a len-8 request.
        start8 = 1'b1; mode8 = 1'b0; len8 = 4'd8; key8 = k8;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("arst_busy", {31'h0, busy8}, 32'h0);
        check("arst_ready", {31'h0, rdy8}, 32'h0);
        check("arst_val", val8, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        pulses = 0;
        for (int c = 0; c < 14; c++) begin
            @(posedge clk); #1;
            if (rdy8) pulses++;
        end
        check("arst_no_pulse", 32'(pulses), 32'd0);
        $display("[TB] reset mid-request, pulses afterwards=%0d", pulses);
        req8("fnv_after_rst", 1'b0, 4'd1, 64'h61, 3, 32'hE40C292C);

        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
